// File: rtl/int_button_conditioner.sv
// Interrupt push-button conditioner: per-channel synchroniser, debounce and
// rising-edge detect, feeding a pending-request latch that holds until acknowledged.
module int_button_conditioner #(
   parameter int N_CH         = 3,
   parameter int DEBOUNCE_CNT = 1000000,
   parameter int CNT_W        = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   input  logic [N_CH-1:0] int_ack,
   output logic [N_CH-1:0] int_req,
   output logic            int_any,
   output logic [1:0]      int_code,
   output logic [N_CH-1:0] btn_level,
   output logic [7:0]      drop_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic [N_CH-1:0]  r_sync1;
   logic [N_CH-1:0]  r_sync2;
   logic [N_CH-1:0]  r_level;
   logic [N_CH-1:0]  r_level_d;
   logic [N_CH-1:0]  r_req;
   logic [CNT_W-1:0] r_cnt [N_CH];
   logic             r_any;
   logic [1:0]       r_code;
   logic [7:0]       r_drop_cnt;

   logic [N_CH-1:0]  w_press;
   logic [N_CH-1:0]  w_req_next;
   logic             w_drop;
   logic [1:0]       w_code_next;

   // Synchronise and debounce; a new level is accepted only after it has
   // persisted for DEBOUNCE_CNT consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_level_d <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1   <= btn_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         for (int i = 0; i < N_CH; i++) begin
            if (r_sync2[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_level[i] <= r_sync2[i];
               r_cnt[i]   <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_press    = r_level & ~r_level_d;
   assign w_req_next = w_press | (r_req & ~int_ack);
   assign w_drop     = |(w_press & r_req & ~int_ack);

   // Descending scan so the lowest-numbered pending channel wins.
   always_comb begin
      w_code_next = 2'd0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_req_next[i]) begin
            w_code_next = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req      <= '0;
         r_any      <= 1'b0;
         r_code     <= 2'd0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_req  <= w_req_next;
         r_any  <= |w_req_next;
         r_code <= w_code_next;
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign int_req   = r_req;
   assign int_any   = r_any;
   assign int_code  = r_code;
   assign btn_level = r_level;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_int_button_conditioner.sv
// Directed self-checking bench for int_button_conditioner with DEBOUNCE_CNT = 4:
// a held press is accepted 5 edges after first sampling, the request 1 edge later.
module tb_int_button_conditioner;

   logic       clk;
   logic       rst_n;
   logic [2:0] btn_raw;
   logic [2:0] int_ack;
   logic [2:0] int_req;
   logic       int_any;
   logic [1:0] int_code;
   logic [2:0] btn_level;
   logic [7:0] drop_cnt;

   int checks = 0;
   int passes = 0;

   int_button_conditioner #(
      .N_CH(3),
      .DEBOUNCE_CNT(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw),
      .int_ack(int_ack),
      .int_req(int_req),
      .int_any(int_any),
      .int_code(int_code),
      .btn_level(btn_level),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      btn_raw = 3'b000;
      int_ack = 3'b000;
      tick(2);
      checks++;
      if ({int_req, int_any, int_code, btn_level, drop_cnt} !== 17'd0)
         $display("[TB] FAIL reset_init: outputs=%h expected 0", {int_req, int_any, int_code, btn_level, drop_cnt});
      else passes++;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_clean_press;
      btn_raw[1] = 1'b1;
      tick(5);
      checks++;
      if (btn_level !== 3'b000) $display("[TB] FAIL press_level_early: btn_level=%b expected 000", btn_level);
      else passes++;
      tick(1);
      checks++;
      if (btn_level !== 3'b010 || int_req !== 3'b000)
         $display("[TB] FAIL press_level: btn_level=%b int_req=%b expected 010/000", btn_level, int_req);
      else passes++;
      tick(1);
      checks++;
      if (int_req !== 3'b010 || int_any !== 1'b1 || int_code !== 2'd1)
         $display("[TB] FAIL press_req: req=%b any=%b code=%0d expected 010/1/1", int_req, int_any, int_code);
      else passes++;
      int_ack = 3'b010;
      tick(1);
      int_ack = 3'b000;
      checks++;
      if (int_req !== 3'b000 || int_any !== 1'b0 || int_code !== 2'd0)
         $display("[TB] FAIL press_ack: req=%b any=%b code=%0d expected 000/0/0", int_req, int_any, int_code);
      else passes++;
      btn_raw[1] = 1'b0;
      tick(5);
      checks++;
      if (btn_level !== 3'b010) $display("[TB] FAIL release_early: btn_level=%b expected 010", btn_level);
      else passes++;
      tick(1);
      checks++;
      if (btn_level !== 3'b000 || int_req !== 3'b000)
         $display("[TB] FAIL release: btn_level=%b req=%b expected 000/000", btn_level, int_req);
      else passes++;
   endtask

   task automatic test_glitch;
      btn_raw[0] = 1'b1;
      tick(3);
      btn_raw[0] = 1'b0;
      tick(10);
      checks++;
      if (btn_level !== 3'b000 || int_req !== 3'b000 || drop_cnt !== 8'd0)
         $display("[TB] FAIL glitch: level=%b req=%b drop=%0d expected 000/000/0", btn_level, int_req, drop_cnt);
      else passes++;
   endtask

   task automatic test_priority;
      btn_raw = 3'b101;
      tick(7);
      checks++;
      if (int_req !== 3'b101 || int_any !== 1'b1 || int_code !== 2'd0)
         $display("[TB] FAIL prio_both: req=%b any=%b code=%0d expected 101/1/0", int_req, int_any, int_code);
      else passes++;
      int_ack = 3'b001;
      tick(1);
      int_ack = 3'b000;
      checks++;
      if (int_req !== 3'b100 || int_any !== 1'b1 || int_code !== 2'd2)
         $display("[TB] FAIL prio_ack0: req=%b any=%b code=%0d expected 100/1/2", int_req, int_any, int_code);
      else passes++;
      int_ack = 3'b100;
      tick(1);
      int_ack = 3'b000;
      checks++;
      if (int_req !== 3'b000 || int_any !== 1'b0 || int_code !== 2'd0)
         $display("[TB] FAIL prio_ack2: req=%b any=%b code=%0d expected 000/0/0", int_req, int_any, int_code);
      else passes++;
      btn_raw = 3'b000;
      tick(6);
   endtask

   task automatic test_collision_drop;
      btn_raw[2] = 1'b1;
      tick(7);
      checks++;
      if (int_req !== 3'b100 || drop_cnt !== 8'd0)
         $display("[TB] FAIL coll_first: req=%b drop=%0d expected 100/0", int_req, drop_cnt);
      else passes++;
      btn_raw[2] = 1'b0;
      tick(6);
      btn_raw[2] = 1'b1;
      tick(7);
      checks++;
      if (int_req !== 3'b100 || drop_cnt !== 8'd1)
         $display("[TB] FAIL coll_drop: req=%b drop=%0d expected 100/1", int_req, drop_cnt);
      else passes++;
      btn_raw[2] = 1'b0;
      tick(6);
      btn_raw[2] = 1'b1;
      tick(6);
      int_ack = 3'b100;
      tick(1);
      int_ack = 3'b000;
      checks++;
      if (int_req !== 3'b100 || drop_cnt !== 8'd1)
         $display("[TB] FAIL coll_setwins: req=%b drop=%0d expected 100/1", int_req, drop_cnt);
      else passes++;
      int_ack = 3'b100;
      tick(1);
      int_ack = 3'b000;
      checks++;
      if (int_req !== 3'b000 || int_any !== 1'b0)
         $display("[TB] FAIL coll_clear: req=%b any=%b expected 000/0", int_req, int_any);
      else passes++;
      btn_raw[2] = 1'b0;
      tick(6);
   endtask

   task automatic test_reset_async;
      btn_raw = 3'b101;
      tick(7);
      checks++;
      if (int_req !== 3'b101) $display("[TB] FAIL rst_setup: req=%b expected 101", int_req);
      else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({int_req, int_any, int_code, btn_level, drop_cnt} !== 17'd0)
         $display("[TB] FAIL reset_async: outputs=%h expected 0", {int_req, int_any, int_code, btn_level, drop_cnt});
      else passes++;
      btn_raw = 3'b000;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_reset_mid_debounce;
      btn_raw[1] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(5);
      checks++;
      if (btn_level !== 3'b000) $display("[TB] FAIL rst_debounce_early: level=%b expected 000", btn_level);
      else passes++;
      tick(1);
      checks++;
      if (btn_level !== 3'b010) $display("[TB] FAIL rst_debounce: level=%b expected 010", btn_level);
      else passes++;
      tick(1);
      int_ack = 3'b010;
      tick(1);
      int_ack = 3'b000;
      btn_raw[1] = 1'b0;
      tick(6);
   endtask

   task automatic test_saturation;
      btn_raw[0] = 1'b1;
      tick(7);
      checks++;
      if (int_req !== 3'b001 || drop_cnt !== 8'd0)
         $display("[TB] FAIL sat_setup: req=%b drop=%0d expected 001/0", int_req, drop_cnt);
      else passes++;
      for (int i = 1; i <= 300; i++) begin
         btn_raw[0] = 1'b0;
         tick(6);
         btn_raw[0] = 1'b1;
         tick(7);
         if (i == 254) begin
            checks++;
            if (drop_cnt !== 8'd254) $display("[TB] FAIL sat_254: drop=%0d expected 254", drop_cnt);
            else passes++;
         end
         if (i == 255) begin
            checks++;
            if (drop_cnt !== 8'd255) $display("[TB] FAIL sat_255: drop=%0d expected 255", drop_cnt);
            else passes++;
         end
      end
      checks++;
      if (drop_cnt !== 8'd255 || int_req !== 3'b001)
         $display("[TB] FAIL sat_hold: drop=%0d req=%b expected 255/001", drop_cnt, int_req);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_priority();
      test_collision_drop();
      test_reset_async();
      test_reset_mid_debounce();
      test_saturation();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
